riscv_mc_control: RTL and testbench

Multi-cycle control sequencer for the sequential 64-bit RISC-V datapath. It accepts one instruction word at a time and walks it through FETCH, DECODE, EXEC, MEM and WB states. In each state it drives the ALU operation select and the datapath enables, and in EXEC it consumes the ALU zero flag for branch resolution. It is the producer side of the ALU control interface: it generates the 2-bit op select the ALU decodes and reads back the ALU's zero flag.

---
 rtl/riscv_mc_control.sv | 189 ++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle control sequencer for the sequential RV64
// datapath. Walks one instruction at a time through FETCH, DECODE, EXEC,
// MEM and WB, driving ALU op select and datapath enables from the
// registered state and the latched instruction fields.
//
// Handshake: in FETCH an instruction is accepted on any rising edge where
// instr_valid=1 (instr_ack is high in that same cycle); in MEM the access
// is held until the edge where mem_ready=1. instr_valid is ignored outside
// FETCH and mem_ready is ignored outside MEM.
//
// Optional feature: define RISCV_MC_CONTROL_PERF_EN to build the retired
// instruction and cycle counters; otherwise both perf outputs read 0.
module riscv_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        instr_ack,
  output logic [1:0]  alu_control,
  output logic        alu_src_b,
  output logic [1:0]  imm_sel,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        illegal_instr,
  output logic [2:0]  state,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_cycles
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Only opcode, funct3 and funct7 steer control; register and immediate
  // fields go straight to the datapath, so they are not stored here.
  logic [6:0] ir_opcode;
  logic [2:0] ir_funct3;
  logic [6:0] ir_funct7;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  logic       is_r, is_addi, is_ld, is_sd, is_beq, is_legal;
  logic [1:0] r_alu;
  logic [1:0] imm_fmt;

  assign state = state_q;

  // Instruction classification from the latched fields.
  always_comb begin
    is_r    = (ir_opcode == 7'b0110011) &&
              (((ir_funct3 == 3'b000) &&
                ((ir_funct7 == 7'b0000000) || (ir_funct7 == 7'b0100000))) ||
               (((ir_funct3 == 3'b110) || (ir_funct3 == 3'b111)) &&
                (ir_funct7 == 7'b0000000)));
    is_addi = (ir_opcode == 7'b0010011) && (ir_funct3 == 3'b000);
    is_ld   = (ir_opcode == 7'b0000011) && (ir_funct3 == 3'b011);
    is_sd   = (ir_opcode == 7'b0100011) && (ir_funct3 == 3'b011);
    is_beq  = (ir_opcode == 7'b1100011) && (ir_funct3 == 3'b000);
    is_legal = is_r || is_addi || is_ld || is_sd || is_beq;
    if (ir_funct3 == 3'b000)      r_alu = ir_funct7[5] ? 2'b01 : 2'b00;
    else if (ir_funct3 == 3'b110) r_alu = 2'b10;
    else                          r_alu = 2'b11;
    if (is_sd)       imm_fmt = 2'b01;
    else if (is_beq) imm_fmt = 2'b10;
    else             imm_fmt = 2'b00;
  end

  // State register and instruction latch; reset drops any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_opcode <= '0;
      ir_funct3 <= '0;
      ir_funct7 <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) begin
        ir_opcode <= instr[6:0];
        ir_funct3 <= instr[14:12];
        ir_funct7 <= instr[31:25];
      end
    end
  end

  // Next-state and Moore outputs; zero_flag passes straight to pc_src in EXEC.
  always_comb begin
    state_d       = state_q;
    instr_ack     = 1'b0;
    alu_control   = 2'b00;
    alu_src_b     = 1'b0;
    imm_sel       = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ack = instr_valid && !reset;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        imm_sel = imm_fmt;
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EXEC: begin
        imm_sel = imm_fmt;
        if (is_r) begin
          alu_control = r_alu;
          state_d     = S_WB;
        end else if (is_addi) begin
          alu_src_b = 1'b1;
          state_d   = S_WB;
        end else if (is_ld || is_sd) begin
          alu_src_b = 1'b1;
          state_d   = S_MEM;
        end else begin
          alu_control = 2'b01;
          pc_write    = 1'b1;
          pc_src      = zero_flag;
          state_d     = S_FETCH;
        end
      end
      S_MEM: begin
        imm_sel   = imm_fmt;
        mem_read  = is_ld;
        mem_write = is_sd;
        if (mem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef RISCV_MC_CONTROL_PERF_EN
  logic retire;
  assign retire = (state_q == S_WB) ||
                  (state_q == S_EXEC && is_beq) ||
                  (state_q == S_MEM && is_sd && mem_ready);

  // Free-running cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (retire) perf_retired <= perf_retired + 32'd1;
    end
  end
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: randomized self-checking bench for riscv_mc_control.
// A transaction-level model expands each instruction into its expected
// per-cycle output vectors and input drive values, held in queues that the
// driver consumes one cycle at a time.
module tb_riscv_mc_control;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        zero_flag;
  logic        mem_ready;
  logic        instr_ack;
  logic [1:0]  alu_control;
  logic        alu_src_b;
  logic [1:0]  imm_sel;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic        pc_src;
  logic        illegal_instr;
  logic [2:0]  state;
  logic [31:0] perf_retired;
  logic [31:0] perf_cycles;

  riscv_mc_control dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .instr_ack(instr_ack),
    .alu_control(alu_control), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .pc_write(pc_write), .pc_src(pc_src),
    .illegal_instr(illegal_instr), .state(state),
    .perf_retired(perf_retired), .perf_cycles(perf_cycles)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: every edge with reset low counts.
  logic [31:0] cyc_m;
  always @(posedge clk) begin
    if (reset) cyc_m <= '0;
    else       cyc_m <= cyc_m + 32'd1;
  end

  // ---------------- scoreboard ----------------
  localparam int W = 16;
  logic [W-1:0] exp_q[$];
  logic [2:0]   in_q[$];    // {instr_valid, mem_ready, zero_flag}
  logic [31:0]  ins_q[$];
  logic [31:0]  ret_m;
  int n_checks;
  int n_pass;

  logic [W-1:0] obs;
  assign obs = {instr_ack, alu_control, alu_src_b, imm_sel, reg_write,
                mem_to_reg, mem_read, mem_write, pc_write, pc_src,
                illegal_instr, state};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [W-1:0] vec(
    input logic ack, input logic [1:0] alu, input logic srcb,
    input logic [1:0] imm, input logic rw, input logic m2r, input logic mr,
    input logic mw, input logic pcw, input logic pcs, input logic ill,
    input logic [2:0] st);
    return {ack, alu, srcb, imm, rw, m2r, mr, mw, pcw, pcs, ill, st};
  endfunction

  // ---------------- reference model ----------------
  // kind: 0 R-type, 1 addi, 2 ld, 3 sd, 4 beq, 5 illegal
  function automatic void classify(input logic [31:0] w, output int kind,
                                   output logic [1:0] alu);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    kind = 5; alu = 2'b00;
    case (op)
      7'b0110011: begin
        if      (f7 == 7'h00 && f3 == 3'd0) begin kind = 0; alu = 2'b00; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin kind = 0; alu = 2'b01; end
        else if (f7 == 7'h00 && f3 == 3'd6) begin kind = 0; alu = 2'b10; end
        else if (f7 == 7'h00 && f3 == 3'd7) begin kind = 0; alu = 2'b11; end
      end
      7'b0010011: if (f3 == 3'd0) kind = 1;
      7'b0000011: if (f3 == 3'd3) kind = 2;
      7'b0100011: if (f3 == 3'd3) kind = 3;
      7'b1100011: if (f3 == 3'd0) kind = 4;
      default: kind = 5;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic iv, input logic mr, input logic zf,
                      input logic [31:0] w, input logic [W-1:0] e);
    in_q.push_back({iv, mr, zf});
    ins_q.push_back(w);
    exp_q.push_back(e);
  endtask

  // Expand one instruction into expected cycles, preceded by idle FETCH cycles.
  task automatic plan(input logic [31:0] w, input logic zf, input int n_mem,
                      input int idle);
    int kind;
    logic [1:0] alu, imm;
    classify(w, kind, alu);
    imm = (kind == 3) ? 2'b01 : (kind == 4) ? 2'b10 : 2'b00;
    for (int i = 0; i < idle; i++)
      push(1'b0, rbit(), rbit(), $urandom, '0);
    push(1'b1, rbit(), rbit(), w, vec(1,0,0,0,0,0,0,0,0,0,0,3'd0));
    if (kind == 5) begin
      push(rbit(), rbit(), rbit(), $urandom, vec(0,0,0,imm,0,0,0,0,1,0,1,3'd1));
      return;
    end
    push(rbit(), rbit(), rbit(), $urandom, vec(0,0,0,imm,0,0,0,0,0,0,0,3'd1));
    case (kind)
      0: push(rbit(), rbit(), rbit(), $urandom, vec(0,alu,0,imm,0,0,0,0,0,0,0,3'd2));
      1, 2, 3: push(rbit(), rbit(), rbit(), $urandom, vec(0,0,1,imm,0,0,0,0,0,0,0,3'd2));
      default: push(rbit(), rbit(), zf, $urandom, vec(0,2'b01,0,imm,0,0,0,0,1,zf,0,3'd2));
    endcase
    if (kind == 2 || kind == 3) begin
      for (int i = 0; i < n_mem; i++) begin
        logic last;
        last = (i == n_mem - 1);
        push(rbit(), last, rbit(), $urandom,
             vec(0,0,0,imm,0,0,kind == 2,kind == 3,last && kind == 3,0,0,3'd3));
      end
    end
    if (kind != 3 && kind != 4)
      push(rbit(), rbit(), rbit(), $urandom, vec(0,0,0,0,1,kind == 2,0,0,1,0,0,3'd4));
    ret_m = ret_m + 32'd1;
  endtask

  task automatic check_perf();
    logic [31:0] er, ec;
`ifdef RISCV_MC_CONTROL_PERF_EN
    er = ret_m; ec = cyc_m;
`else
    er = '0; ec = '0;
`endif
    check_eq("perf_retired", perf_retired, er);
    check_eq("perf_cycles", perf_cycles, ec);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; applies one queued cycle and checks it at negedge.
  task automatic drain();
    logic [2:0] in;
    logic [W-1:0] e;
    while (in_q.size() > 0) begin
      in = in_q.pop_front();
      instr = ins_q.pop_front();
      e = exp_q.pop_front();
      {instr_valid, mem_ready, zero_flag} = in;
      @(negedge clk);
      check_eq("ctl", 32'(obs), 32'(e));
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    check_perf();
  endtask

  task automatic run(input logic [31:0] w, input logic zf, input int n_mem,
                     input int idle);
    plan(w, zf, n_mem, idle);
    drain();
  endtask

  task automatic step_cycle();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] gen(input int kind);
    logic [11:0] imm12;
    logic [4:0] rs1, rs2, rd;
    imm12 = 12'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    rd = 5'($urandom);
    case (kind)
      0: case ($urandom_range(0, 3))
           0: return {7'h00, rs2, rs1, 3'd0, rd, 7'b0110011};
           1: return {7'h20, rs2, rs1, 3'd0, rd, 7'b0110011};
           2: return {7'h00, rs2, rs1, 3'd6, rd, 7'b0110011};
           default: return {7'h00, rs2, rs1, 3'd7, rd, 7'b0110011};
         endcase
      1: return {imm12, rs1, 3'd0, rd, 7'b0010011};
      2: return {imm12, rs1, 3'd3, rd, 7'b0000011};
      3: return {imm12[11:5], rs2, rs1, 3'd3, imm12[4:0], 7'b0100011};
      4: return {imm12[11:5], rs2, rs1, 3'd0, imm12[4:0], 7'b1100011};
      default: case ($urandom_range(0, 3))
           0: return $urandom;
           1: return {7'h01, rs2, rs1, 3'd0, rd, 7'b0110011};
           2: return {imm12, rs1, 3'd2, rd, 7'b0000011};
           default: return {imm12[11:5], rs2, rs1, 3'd1, imm12[4:0], 7'b1100011};
         endcase
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; ret_m = '0;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    zero_flag = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_vec", 32'(obs), 32'd0);
    check_perf();
    reset = 1'b0;

    // Directed cases from the plan, back to back.
    run(32'h002081B3, 1'b0, 1, 0);  // add
    run(32'h402081B3, 1'b0, 1, 0);  // sub
    run(32'h0020E1B3, 1'b0, 1, 0);  // or
    run(32'h0020F1B3, 1'b0, 1, 0);  // and
    run(32'h00208463, 1'b1, 1, 0);  // beq taken
    run(32'h00208463, 1'b0, 1, 1);  // beq not taken
    run(32'h0000B283, 1'b0, 3, 0);  // ld, 3 MEM cycles
    run(32'h0020B023, 1'b0, 1, 0);  // sd, immediate ready
    run(32'hFFFFFFFF, 1'b0, 1, 0);  // illegal
    run(32'h00000013, 1'b0, 1, 2);  // addi

    // Reset during the 2nd MEM cycle of ld.
    instr = 32'h0000B283; instr_valid = 1'b1; mem_ready = 1'b0;
    step_cycle();
    instr_valid = 1'b0;
    step_cycle();
    step_cycle();
    @(negedge clk);
    check_eq("ld_mem1_state", 32'(state), 32'd3);
    check_eq("ld_mem1_read", 32'(mem_read), 32'd1);
    step_cycle();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    ret_m = '0;
    check_eq("post_reset_vec", 32'(obs), 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_ready_vec", 32'(obs), 32'd0);
      step_cycle();
    end
    mem_ready = 1'b0;
    check_perf();

    // Randomized traffic.
    for (int i = 0; i < 60; i++)
      run(gen($urandom_range(0, 5)), rbit(), $urandom_range(1, 4),
          $urandom_range(0, 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
